// File: rtl/aurora_tx_pkg.sv
// Shared definitions for the four-lane Aurora TX scheduler.
//   IDLE_WORD  - payload of the idle control block sent when a lane has nothing to send
//   SYNC_DATA  - sync header of a data block
//   SYNC_CTRL  - sync header of a control block
//   tx_state_t - scheduler link state
package aurora_tx_pkg;

  localparam int NUM_LANES = 4;
  localparam int BLOCK_W   = 65;  // {ctrl, payload[63:0]}

  localparam logic [63:0] IDLE_WORD = 64'h7800_0000_0000_0000;
  localparam logic [1:0]  SYNC_DATA = 2'b01;
  localparam logic [1:0]  SYNC_CTRL = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BOND  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } tx_state_t;

endpackage

// File: rtl/tx_lane_fifo.sv
// Per-lane block buffer: synchronous FIFO, WIDTH bits wide, DEPTH entries deep.
// Ports:
//   clk, reset_n        - clock and synchronous active-low reset (empties the FIFO)
//   push, push_data     - write one entry (ignored when full)
//   pop                 - discard the head entry (ignored when empty)
//   head                - current head entry, valid while empty=0
//   full, empty         - occupancy flags, derived from registered pointers
module tx_lane_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr_reg[AW-1:0]];

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/aurora_tx_lane_scheduler.sv
// Stripes an upstream 64b/66b block stream across four Aurora TX lanes.
// After link_en the lanes send BOND_BLOCKS idle blocks each (BOND), then the
// link runs (RUN) and accepted blocks go round-robin into per-lane FIFOs.
// Dropping link_en drains the FIFOs (DRAIN) before returning to IDLE.
// Ports:
//   clk, reset_n       - clock, synchronous active-low reset
//   link_en            - link enable; low requests orderly shutdown
//   s_data/s_ctrl      - upstream block payload and control flag
//   s_valid/s_ready    - upstream handshake
//   data_next[3:0]     - per-lane request: lane i captured data_out[i]/sync_out[i]
//   data_out/sync_out  - per-lane block payload and sync header
//   link_ready         - high in RUN only
module aurora_tx_lane_scheduler
  import aurora_tx_pkg::*;
#(
  parameter int BOND_BLOCKS = 32,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        link_en,
  input  logic [63:0] s_data,
  input  logic        s_ctrl,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [3:0]  data_next,
  output logic [63:0] data_out [NUM_LANES],
  output logic [1:0]  sync_out [NUM_LANES],
  output logic        link_ready
);

  localparam int CW = $clog2(BOND_BLOCKS + 1);

  tx_state_t          state_reg;
  tx_state_t          state_next;
  logic [1:0]         wr_lane_reg;
  logic [CW-1:0]      bond_cnt_reg [NUM_LANES];
  logic [NUM_LANES-1:0] full;
  logic [NUM_LANES-1:0] empty;
  logic [NUM_LANES-1:0] push;
  logic [NUM_LANES-1:0] pop;
  logic [NUM_LANES-1:0] bond_done;
  logic [BLOCK_W-1:0] head [NUM_LANES];
  logic [BLOCK_W-1:0] push_word;
  logic               xfer;
  logic               serving;

  assign s_ready    = (state_reg == ST_RUN) & ~full[wr_lane_reg];
  assign xfer       = s_valid & s_ready;
  assign link_ready = (state_reg == ST_RUN);
  assign serving    = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
  assign push_word  = {s_ctrl, s_data};

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (link_en)     state_next = ST_BOND;
      ST_BOND:  if (&bond_done)  state_next = ST_RUN;
      ST_RUN:   if (!link_en)    state_next = ST_DRAIN;
      ST_DRAIN: if (&empty)      state_next = ST_IDLE;
      default:                   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg   <= ST_IDLE;
      wr_lane_reg <= 2'd0;
    end else begin
      state_reg <= state_next;
      // Two-bit counter wraps 3->0 on its own.
      if (xfer) wr_lane_reg <= wr_lane_reg + 2'd1;
    end
  end

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    assign push[gi]      = xfer && (wr_lane_reg == 2'(gi));
    assign pop[gi]       = data_next[gi] & serving & ~empty[gi];
    assign bond_done[gi] = (bond_cnt_reg[gi] == CW'(BOND_BLOCKS));

    tx_lane_fifo #(
      .WIDTH (BLOCK_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push[gi]),
      .push_data (push_word),
      .pop       (pop[gi]),
      .head      (head[gi]),
      .full      (full[gi]),
      .empty     (empty[gi])
    );

    // Held at zero outside BOND, so every entry into BOND starts from zero.
    always_ff @(posedge clk) begin
      if (!reset_n || state_reg != ST_BOND) begin
        bond_cnt_reg[gi] <= '0;
      end else if (data_next[gi] && !bond_done[gi]) begin
        bond_cnt_reg[gi] <= bond_cnt_reg[gi] + 1'b1;
      end
    end

    // The head is read from pre-edge FIFO state, so a block pushed at this
    // same edge into an empty FIFO is not visible and the lane sends idle.
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        data_out[gi] <= IDLE_WORD;
        sync_out[gi] <= SYNC_CTRL;
      end else if (data_next[gi]) begin
        if (pop[gi]) begin
          data_out[gi] <= head[gi][63:0];
          sync_out[gi] <= head[gi][64] ? SYNC_CTRL : SYNC_DATA;
        end else begin
          data_out[gi] <= IDLE_WORD;
          sync_out[gi] <= SYNC_CTRL;
        end
      end
    end
  end

endmodule

// File: doc/aurora_tx_lane_scheduler.md
AURORA_TX_LANE_SCHEDULER -- requirements
Module: aurora_tx_lane_scheduler

Interface
REQ-001 Parameter BOND_BLOCKS, default 32, is the number of idle blocks each lane sends in BOND before RUN.
REQ-002 Parameter FIFO_DEPTH, default 4, is the per-lane buffer depth in blocks; it is a power of 2, at least 2.
REQ-003 clk  in  1  single logic clock; all state is updated on its rising edge.
REQ-004 reset_n  in  1  synchronous, active-low reset.
REQ-005 link_en  in  1  enables the link; low requests orderly shutdown.
REQ-006 s_data  in  64  block payload from the upstream stream.
REQ-007 s_ctrl  in  1  1 = control block (sync 2'b10), 0 = data block (sync 2'b01).
REQ-008 s_valid  in  1  upstream block valid.
REQ-009 s_ready  out  1  scheduler accepts the block; a transfer occurs on s_valid & s_ready at a rising edge.
REQ-010 data_next  in  4  per-lane request from the TX lanes; bit i high at an edge means lane i captured data_out[i]/sync_out[i].
REQ-011 data_out  out  64 x 4 (unpacked [4])  per-lane block payload.
REQ-012 sync_out  out  2 x 4 (unpacked [4])  per-lane sync header.
REQ-013 link_ready  out  1  high only in state RUN.

Function
REQ-014 FSM states: IDLE, BOND, RUN, DRAIN.
REQ-015 Transition IDLE->BOND occurs when link_en=1.
REQ-016 Transition BOND->RUN occurs when all four lane bond counters have reached BOND_BLOCKS.
REQ-017 Transition RUN->DRAIN occurs when link_en=0.
REQ-018 Transition DRAIN->IDLE occurs when all lane FIFOs are empty; a DRAIN exit ignores link_en.
REQ-019 In BOND, each lane has its own counter, which increments on that lane's data_next bit and saturates at BOND_BLOCKS; counters clear on entry to BOND.
REQ-020 s_ready = (state==RUN) & ~full[wr_lane]; it is combinational from registered state.
REQ-021 Striping: accepted blocks are written round-robin to lane FIFOs 0,1,2,3,0...; the 2-bit wr_lane advances only on a transfer and wraps 3->0.
REQ-022 FIFO entries store {s_ctrl, s_data} (65 bits).
REQ-023 On data_next[i] in RUN or DRAIN with FIFO i non-empty, lane i pops its FIFO and loads the head into data_out[i]/sync_out[i] at the same edge.
REQ-024 In all other cases, data_next[i] loads the idle block: data_out[i]=IDLE_WORD, sync_out[i]=SYNC_CTRL. These cases are: FIFO i empty, state IDLE, or state BOND.
REQ-025 Outputs hold their value while data_next[i]=0.
REQ-026 Lanes pop independently; simultaneous data_next bits are all serviced in the same cycle.
REQ-027 Latency: a block accepted at edge T is eligible to be loaded at the first data_next[i] edge at or after T+1; there is no write-to-read bypass. An empty FIFO written and popped at the same edge outputs idle.
REQ-028 Pushing into a full FIFO is impossible by REQ-020. A push and a pop at the same edge on a non-full FIFO both take effect.
REQ-029 Per-lane order is preserved; no block is dropped or duplicated.

Reset
REQ-030 While reset_n=0 at an edge, the following apply:
  - state=IDLE, wr_lane=0;
  - all FIFOs are emptied and bond counters cleared;
  - data_out[i]=IDLE_WORD, sync_out[i]=SYNC_CTRL for all i;
  - link_ready=0 and s_ready=0.
REQ-031 A reset asserted mid-operation (any state) discards buffered blocks; outputs are idle at the next edge.

Structure
REQ-032 Shared package aurora_tx_pkg holds:
  - IDLE_WORD = 64'h7800_0000_0000_0000;
  - SYNC_DATA = 2'b01, SYNC_CTRL = 2'b10;
  - the FSM state enum typedef.
REQ-033 One sub-module, tx_lane_fifo (65-bit wide, FIFO_DEPTH deep, synchronous, full/empty flags, reset_n), is instantiated 4x in a generate loop.
REQ-034 The block connects directly to the four-lane Aurora TX:
  - data_out/sync_out drive its data_in/sync;
  - data_next is its data_next.

Verification
REQ-035 BOND with BOND_BLOCKS=32 and data_next=4'hF every 4th cycle from link_en rise:
  - 32 idle blocks per lane, then link_ready rises;
  - s_ready=0 throughout BOND.
REQ-036 BOND with skewed lanes (lane 3 requests at half rate): RUN is entered only after lane 3's 32nd request.
REQ-037 Striping: push 8 blocks D0..D7 with s_ctrl=0 in RUN, then data_next=4'hF twice:
  - lane0 = D0, D4; lane1 = D1, D5; lane2 = D2, D6; lane3 = D3, D7;
  - all sync_out=2'b01.
REQ-038 Backpressure: data_next=0 and s_valid=1 held in RUN:
  - exactly 16 transfers, then s_ready=0;
  - one data_next[0] pulse re-enables exactly one transfer when wr_lane=0.
REQ-039 Shutdown and reset:
  - link_en dropped with 5 blocks buffered gives DRAIN; all 5 emerge in order, then IDLE and idle blocks;
  - reset_n=0 mid-RUN gives all FIFOs empty and data_out=IDLE_WORD at the next edge.
